apb_reg_slave: RTL and testbench

APB completer that terminates the APB side of the AHB-to-APB bridge and implements a small memory-mapped 32-bit register bank. It samples setup/access phases from the bridge, optionally inserts a fixed number of wait states via PREADY, and commits writes or returns read data. Misaligned, out-of-range, or illegal accesses are flagged with PSLVERR. It is the standard end-point used to exercise and verify the bridge.

---
 rtl/apb_slv_pkg.sv | 17 +
 rtl/apb_slv_regfile.sv | 39 +++
 rtl/apb_reg_slave.sv | 164 ++++++++++++++++
 tb/tb_apb_reg_slave.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg
//   Shared types and constants for the APB register completer.
//   - apb_slv_state_t : phase the completer expects in the current cycle
//   - ID_REG_IDX      : index of the read-only identification register
//   - WAIT_CNT_W      : width of the wait-state counter
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_state_t;

    localparam int unsigned ID_REG_IDX = 0;
    localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_slv_regfile.sv
// apb_slv_regfile
//   Bank of NUM_REGS 32-bit registers. Index 0 is hardwired to ID_VALUE and
//   ignores writes; all other entries reset to 0.
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     we_i          : write strobe, takes effect on the rising edge
//     idx_i         : register index for both read and write
//     wdata_i       : write data
//     rdata_o       : combinational read data for idx_i
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IDX_W    = 3,
    parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (idx_i != IDX_W'(ID_REG_IDX))) begin
            regs_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = (idx_i == IDX_W'(ID_REG_IDX)) ? ID_VALUE : regs_q[idx_i];

endmodule

// File: rtl/apb_reg_slave.sv
// apb_reg_slave
//   APB completer with a small 32-bit register bank. Setup-phase address,
//   direction and data are latched and decoded once; the access phase then
//   runs from those latched values, optionally stretched by wait states.
//   Optional feature: define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait
//   states per transfer; otherwise every transfer is zero-wait.
//   Ports:
//     HCLK, HRESETn   : clock, asynchronous active-low reset
//     PSEL, PENABLE   : APB select / access-phase indicator
//     PWRITE          : 1 = write, 0 = read
//     PADDR, PWDATA   : byte address, write data (sampled in setup only)
//     PRDATA          : read data, non-zero only in READY for a good read
//     PREADY          : high in READY; transfer completes when PSEL&PENABLE
//     PSLVERR         : error response, only in READY
//     dbg_state_o     : current FSM state
//   Handshake: a transfer completes on the rising edge where PSEL, PENABLE
//   and PREADY are all 1; PSEL or PENABLE low in WAIT/READY aborts it.
module apb_reg_slave
    import apb_slv_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    apb_slv_state_t   state_q, state_d;
    logic             write_q, write_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
`ifdef APB_SLV_WAIT_EN
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic        setup_cyc;
    logic        access_cyc;
    logic        commit;
    logic [31:0] offset;
    logic [31:0] word_idx;
    logic        dec_err;
    logic [31:0] reg_rdata;

    assign setup_cyc  = PSEL & ~PENABLE;
    assign access_cyc = PSEL & PENABLE;

    // Unsigned wrap-around is harmless: addresses below the base are caught
    // by the explicit compare, so a wrapped offset never reaches the bank.
    assign offset   = PADDR - BASE_ADDR;
    assign word_idx = offset >> 2;
    assign dec_err  = (PADDR[1:0] != 2'b00)
                   || (PADDR < BASE_ADDR)
                   || (word_idx >= 32'(NUM_REGS))
                   || (PWRITE && (word_idx == 32'(ID_REG_IDX)));

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (setup_cyc) begin
                    write_d = PWRITE;
                    err_d   = dec_err;
                    idx_d   = offset[IDX_W+1:2];
                    wdata_d = PWDATA;
`ifdef APB_SLV_WAIT_EN
                    if (WAIT_CYCLES != 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = READY;
                    end
`else
                    state_d = READY;
`endif
                end
            end
`ifdef APB_SLV_WAIT_EN
            WAIT: begin
                if (!access_cyc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            READY: begin
                // Completion and abort both leave READY; only a real
                // completion of a clean write touches the bank.
                state_d = IDLE;
                commit  = access_cyc & write_q & ~err_q;
`ifdef APB_SLV_WAIT_EN
                cnt_d   = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    apb_slv_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .we_i    (commit),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (reg_rdata)
    );

    assign PREADY      = (state_q == READY);
    assign PSLVERR     = PREADY & err_q;
    assign PRDATA      = (PREADY && !write_q && !err_q) ? reg_rdata : 32'h0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave
//   Self-checking bench for apb_reg_slave: vector table of APB transfers,
//   a response queue, and hand-written abort / reset-in-flight sequences.
module tb_apb_reg_slave;
  import apb_slv_pkg::*;

  localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLV_WAIT_EN
  localparam int W_EXP = 2;
`else
  localparam int W_EXP = 0;
`endif
  localparam int NV = 15;
  localparam int BUDGET = 20;

  logic        HCLK;
  logic        HRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [1:0]  dbg_state;

  apb_reg_slave #(
    .NUM_REGS    (8),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (2),
    .ID_VALUE    (ID)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  // {is_read, exp_err, exp_rdata}
  logic [33:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the completing edge.
  task automatic apb_xfer(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err);
    logic [33:0] e;
    int cyc;
    exp_q.push_back({~wr, exp_err, exp_rdata});
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    // Address/data move during access; the completer must keep setup values.
    PADDR   = ~addr;
    PWDATA  = ~wdata;
    @(negedge HCLK);
    cyc = 1;
    while (PREADY !== 1'b1 && cyc < BUDGET) begin
      @(negedge HCLK);
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(W_EXP + 1));
    e = exp_q.pop_front();
    if (PREADY === 1'b1) begin
      check({name, "_pslverr"}, {31'h0, PSLVERR}, {31'h0, e[32]});
      if (e[33]) check({name, "_prdata"}, PRDATA, e[31:0]);
    end
    @(posedge HCLK); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [31:0] rnd_addr;
    logic [31:0] rnd_data;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,           ID,            1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,           32'h0,         1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF,   32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,           32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h1234_5678,   32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,           ID,            1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0006, 32'h5555_5555,   32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0004, 32'h0,           32'h0,         1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0,           32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h0000_001C, 32'h1111_2222,   32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h0000_001C, 32'h0,           32'h1111_2222, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_001E, 32'h0,           32'h0,         1'b1};
    vecs[12] = '{1'b1, 32'h0000_0020, 32'h7777_7777,   32'h0,         1'b1};
    vecs[13] = '{1'b0, 32'h0000_0008, 32'h0,           32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,           32'h0,         1'b1};

    HRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;

    // reset state
    @(negedge HCLK);
    check("rst_pready",  {31'h0, PREADY},  32'h0);
    check("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    check("rst_prdata",  PRDATA,           32'h0);
    check("rst_state",   {30'h0, dbg_state}, {30'h0, IDLE});
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // table of single transfers
    for (int i = 0; i < NV; i++) begin
      apb_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // back-to-back transfers, no idle cycle between them
    apb_xfer("b2b_wr4", 1'b1, 32'h4, 32'hAAAA_0004, 32'h0, 1'b0);
    apb_xfer("b2b_wrC", 1'b1, 32'hC, 32'hCCCC_000C, 32'h0, 1'b0);
    apb_xfer("b2b_rdC", 1'b0, 32'hC, 32'h0,         32'hCCCC_000C, 1'b0);
    apb_xfer("b2b_rd4", 1'b0, 32'h4, 32'h0,         32'hAAAA_0004, 1'b0);

    // abort: PSEL dropped before completion of a write to 0x10
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h10; PWDATA = 32'h0BAD_0010;
    @(posedge HCLK); #1;
    if (W_EXP >= 2) begin
      PENABLE = 1'b1;
      @(posedge HCLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    check("abort_state",   {30'h0, dbg_state}, {30'h0, IDLE});
    check("abort_pready",  {31'h0, PREADY},    32'h0);
    check("abort_pslverr", {31'h0, PSLVERR},   32'h0);
    @(posedge HCLK); #1;
    apb_xfer("abort_rd10", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    apb_xfer("abort_next_wr", 1'b1, 32'h10, 32'h1010_1010, 32'h0, 1'b0);
    apb_xfer("abort_next_rd", 1'b0, 32'h10, 32'h0, 32'h1010_1010, 1'b0);

    // random write/readback on upper registers
    for (int k = 0; k < 4; k++) begin
      rnd_addr = 32'($urandom_range(5, 7)) << 2;
      rnd_data = $urandom;
      apb_xfer($sformatf("rnd_wr%0d", k), 1'b1, rnd_addr, rnd_data, 32'h0, 1'b0);
      apb_xfer($sformatf("rnd_rd%0d", k), 1'b0, rnd_addr, 32'h0, rnd_data, 1'b0);
    end

    // reset asserted during READY of a write to 0x14
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h14; PWDATA = 32'h1414_1414;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK);
    cyc = 1;
    while (PREADY !== 1'b1 && cyc < BUDGET) begin
      @(negedge HCLK);
      cyc++;
    end
    check("rstmid_reached_ready", {31'h0, PREADY}, 32'h1);
    HRESETn = 1'b0;
    #1;
    check("rstmid_pready",  {31'h0, PREADY},    32'h0);
    check("rstmid_pslverr", {31'h0, PSLVERR},   32'h0);
    check("rstmid_prdata",  PRDATA,             32'h0);
    check("rstmid_state",   {30'h0, dbg_state}, {30'h0, IDLE});
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    apb_xfer("rstmid_rd14", 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);
    apb_xfer("rstmid_rd8",  1'b0, 32'h8,  32'h0, 32'h0, 1'b0);
    apb_xfer("rstmid_rd0",  1'b0, 32'h0,  32'h0, ID,    1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
